// File: rtl/match_stage_sequencer.sv
// Input register and result register around the combinational two-word matching stage,
// with dictionary write qualification and a one-cycle dictionary clear after each block.
module match_stage_sequencer #(
  parameter int WIDTH      = 64,
  parameter int RES_W      = 40,
  parameter int DICT_ENTRY = 16,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_word,
  input  logic             i_in_last,
  output logic [WIDTH-1:0] o_mw_word,
  input  logic [RES_W-1:0] i_mw_result,
  input  logic [1:0]       i_mw_wr,
  output logic [1:0]       o_dict_wr,
  output logic             o_dict_clear,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [RES_W-1:0] o_out_result,
  output logic             o_out_last,
  output logic [4:0]       o_dict_fill,
  output logic [CNT_W-1:0] o_word_count,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic             r_s1Valid;
  logic             r_s1Last;
  logic             w_adv;
  logic             w_accept;
  logic [4:0]       w_fillSum;

  assign w_adv = r_s1Valid && (!o_out_valid || i_out_ready);

  // A last word sitting in S1 blocks new input until the clear cycle has run.
  assign o_in_ready = i_reset && (r_state != CLEAR) && !(r_s1Valid && r_s1Last) &&
                      (!r_s1Valid || w_adv);
  assign w_accept   = i_in_valid && o_in_ready;
  assign o_dict_wr  = i_mw_wr & {2{w_adv}};
  assign o_busy     = (r_state != IDLE) || r_s1Valid || o_out_valid;
  assign w_fillSum  = o_dict_fill + 5'(o_dict_wr[0]) + 5'(o_dict_wr[1]);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    o_dict_clear = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_stateNext = RUN;
      end
      RUN: begin
        if (w_adv && r_s1Last) w_stateNext = CLEAR;
      end
      CLEAR: begin
        o_dict_clear = 1'b1;
        w_stateNext  = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_s1Valid <= 1'b0;
      r_s1Last  <= 1'b0;
      o_mw_word <= '0;
    end else if (w_accept) begin
      r_s1Valid <= 1'b1;
      r_s1Last  <= i_in_last;
      o_mw_word <= i_in_word;
    end else if (w_adv) begin
      r_s1Valid <= 1'b0;
      r_s1Last  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_out_valid  <= 1'b0;
      o_out_result <= '0;
      o_out_last   <= 1'b0;
    end else if (w_adv) begin
      o_out_valid  <= 1'b1;
      o_out_result <= i_mw_result;
      o_out_last   <= r_s1Last;
    end else if (i_out_ready) begin
      o_out_valid  <= 1'b0;
    end
  end

  // Both counters restart for every block; the clear cycle never carries an adv.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_dict_fill  <= '0;
      o_word_count <= '0;
    end else if (r_state == CLEAR) begin
      o_dict_fill  <= '0;
      o_word_count <= '0;
    end else begin
      if (w_fillSum > 5'(DICT_ENTRY)) begin
        o_dict_fill <= 5'(DICT_ENTRY);
      end else begin
        o_dict_fill <= w_fillSum;
      end
      if (w_adv && (o_word_count != {CNT_W{1'b1}})) begin
        o_word_count <= o_word_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_match_stage_sequencer.sv
// Bench for match_stage_sequencer: a table of throughput vectors plus hand-written stall,
// block-end, partial-write and reset sequences, with results tracked by a scoreboard queue.
module tb_match_stage_sequencer;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [63:0] inWord;
  logic        inLast;
  logic [63:0] mwWord;
  logic [39:0] mwResult;
  logic [1:0]  mwWr;
  logic [1:0]  dictWr;
  logic        dictClear;
  logic        outValid;
  logic        outReady;
  logic [39:0] outResult;
  logic        outLast;
  logic [4:0]  dictFill;
  logic [15:0] wordCount;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [39:0] sb[$];
  logic [63:0] heldWord;

  typedef struct {
    logic        valid;
    logic        expInReady;
    logic        expOutValid;
    logic [1:0]  expDictWr;
    logic [4:0]  expFill;
    logic [15:0] expCount;
  } vec_t;

  vec_t tbl[15];

  // Stand-in for the matching stage: any fixed mixing of the word will do.
  function automatic logic [39:0] mwFunc(input logic [63:0] w);
    return {w[63:56] ^ w[7:0], w[31:0]};
  endfunction

  function automatic vec_t mkVec(input logic v, input logic r, input logic ov,
                                 input logic [1:0] wr, input logic [4:0] f, input logic [15:0] c);
    vec_t t;
    t.valid = v; t.expInReady = r; t.expOutValid = ov;
    t.expDictWr = wr; t.expFill = f; t.expCount = c;
    return t;
  endfunction

  assign mwResult = mwFunc(mwWord);

  match_stage_sequencer dut (
    .i_clk(clk), .i_reset(rstN),
    .i_in_valid(inValid), .o_in_ready(inReady), .i_in_word(inWord), .i_in_last(inLast),
    .o_mw_word(mwWord), .i_mw_result(mwResult), .i_mw_wr(mwWr),
    .o_dict_wr(dictWr), .o_dict_clear(dictClear),
    .o_out_valid(outValid), .i_out_ready(outReady), .o_out_result(outResult),
    .o_out_last(outLast), .o_dict_fill(dictFill), .o_word_count(wordCount), .o_busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one cycle's inputs after the falling edge, then settles and scores any handshakes.
  task automatic applyStimulus(input logic v, input logic last, input logic rdy,
                               input logic [1:0] wr, input logic [63:0] word);
    logic [39:0] exp;
    @(negedge clk);
    inValid = v; inLast = last; outReady = rdy; mwWr = wr; inWord = word;
    #1;
    if (outValid && outReady) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_result", 64'(outResult), 64'hDEAD);
      end else begin
        exp = sb.pop_front();
        checkOutput("result", 64'(outResult), 64'(exp));
      end
    end
    if (inValid && inReady) sb.push_back(mwFunc(word));
  endtask

  initial begin
    rstN = 1'b0; inValid = 1'b1; inLast = 1'b0; outReady = 1'b1; mwWr = 2'b11;
    inWord = 64'h0123_4567_89AB_CDEF;

    // T1: held in reset with a valid word presented
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.inReady", inReady, 0);
    checkOutput("rst.outValid", outValid, 0);
    checkOutput("rst.dictWr", dictWr, 0);
    checkOutput("rst.dictClear", dictClear, 0);
    checkOutput("rst.busy", busy, 0);
    @(negedge clk);
    inValid = 1'b0;
    rstN = 1'b1;

    // T2: back-to-back words, fill saturation and word count
    tbl[0]  = mkVec(1, 1, 0, 2'b00, 0, 0);
    tbl[1]  = mkVec(1, 1, 0, 2'b11, 0, 0);
    tbl[2]  = mkVec(1, 1, 1, 2'b11, 2, 1);
    tbl[3]  = mkVec(1, 1, 1, 2'b11, 4, 2);
    tbl[4]  = mkVec(0, 1, 1, 2'b11, 6, 3);
    tbl[5]  = mkVec(0, 1, 1, 2'b00, 8, 4);
    tbl[6]  = mkVec(1, 1, 0, 2'b00, 8, 4);
    tbl[7]  = mkVec(1, 1, 0, 2'b11, 8, 4);
    tbl[8]  = mkVec(1, 1, 1, 2'b11, 10, 5);
    tbl[9]  = mkVec(1, 1, 1, 2'b11, 12, 6);
    tbl[10] = mkVec(0, 1, 1, 2'b11, 14, 7);
    tbl[11] = mkVec(0, 1, 1, 2'b00, 16, 8);
    tbl[12] = mkVec(1, 1, 0, 2'b00, 16, 8);
    tbl[13] = mkVec(0, 1, 0, 2'b11, 16, 8);
    tbl[14] = mkVec(0, 1, 1, 2'b00, 16, 9);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].valid, 1'b0, 1'b1, 2'b11, {$urandom, $urandom});
      checkOutput($sformatf("t2[%0d].inReady", i), inReady, tbl[i].expInReady);
      checkOutput($sformatf("t2[%0d].outValid", i), outValid, tbl[i].expOutValid);
      checkOutput($sformatf("t2[%0d].dictWr", i), dictWr, tbl[i].expDictWr);
      checkOutput($sformatf("t2[%0d].fill", i), dictFill, tbl[i].expFill);
      checkOutput($sformatf("t2[%0d].count", i), wordCount, tbl[i].expCount);
    end

    // T3: downstream stall holds word 2 in S1 and suppresses its write
    applyStimulus(1, 0, 1, 2'b11, {$urandom, $urandom});
    heldWord = {$urandom, $urandom};
    applyStimulus(1, 0, 0, 2'b11, heldWord);
    checkOutput("t3.acceptW2", inReady, 1);
    heldWord = {$urandom, $urandom};
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 2'b11, heldWord);
      checkOutput($sformatf("t3.stallReady%0d", i), inReady, 0);
      checkOutput($sformatf("t3.stallWr%0d", i), dictWr, 0);
      checkOutput($sformatf("t3.stallValid%0d", i), outValid, 1);
    end
    applyStimulus(1, 0, 1, 2'b11, heldWord);
    checkOutput("t3.releaseWr", dictWr, 2'b11);
    applyStimulus(0, 0, 1, 2'b11, 64'h0);
    applyStimulus(0, 0, 1, 2'b11, 64'h0);
    checkOutput("t3.dictWrIdle", dictWr, 0);
    checkOutput("t3.count", wordCount, 12);

    // T4: block end, clear pulse and restart
    applyStimulus(1, 1, 1, 2'b11, {$urandom, $urandom});
    heldWord = {$urandom, $urandom};
    applyStimulus(1, 0, 1, 2'b11, heldWord);
    checkOutput("t4.lastBlocks", inReady, 0);
    applyStimulus(1, 0, 1, 2'b11, heldWord);
    checkOutput("t4.clear", dictClear, 1);
    checkOutput("t4.clearReady", inReady, 0);
    checkOutput("t4.outLast", outLast, 1);
    applyStimulus(1, 0, 1, 2'b01, heldWord);
    checkOutput("t4.clearOnce", dictClear, 0);
    checkOutput("t4.readyAfter", inReady, 1);
    checkOutput("t4.fillZero", dictFill, 0);
    checkOutput("t4.countZero", wordCount, 0);

    // T5: partial dictionary writes, and writes ignored without an advance
    applyStimulus(1, 0, 1, 2'b01, {$urandom, $urandom});
    checkOutput("t5.wr01", dictWr, 2'b01);
    applyStimulus(0, 0, 1, 2'b10, 64'h0);
    checkOutput("t5.wr10", dictWr, 2'b10);
    checkOutput("t5.fill1", dictFill, 1);
    applyStimulus(0, 0, 1, 2'b11, 64'h0);
    checkOutput("t5.noAdv", dictWr, 0);
    checkOutput("t5.fill2", dictFill, 2);

    // Last word stuck behind a stalled output: clear waits for its advance
    applyStimulus(1, 0, 0, 2'b00, {$urandom, $urandom});
    applyStimulus(1, 1, 0, 2'b00, {$urandom, $urandom});
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 2'b00, 64'h0);
      checkOutput($sformatf("stallLast.noClear%0d", i), dictClear, 0);
      checkOutput($sformatf("stallLast.ready%0d", i), inReady, 0);
    end
    applyStimulus(0, 0, 1, 2'b00, 64'h0);
    checkOutput("stallLast.advNoClear", dictClear, 0);
    applyStimulus(0, 0, 1, 2'b00, 64'h0);
    checkOutput("stallLast.clear", dictClear, 1);
    checkOutput("stallLast.outLast", outLast, 1);

    // T6: asynchronous reset with both stages full
    applyStimulus(1, 0, 0, 2'b11, {$urandom, $urandom});
    applyStimulus(1, 0, 0, 2'b11, {$urandom, $urandom});
    applyStimulus(0, 0, 0, 2'b11, 64'h0);
    checkOutput("t6.preBusy", busy, 1);
    rstN = 1'b0;
    #1;
    sb.delete();
    checkOutput("t6.outValid", outValid, 0);
    checkOutput("t6.inReady", inReady, 0);
    checkOutput("t6.result", 64'(outResult), 0);
    checkOutput("t6.mwWord", mwWord, 0);
    checkOutput("t6.busy", busy, 0);
    checkOutput("t6.dictClear", dictClear, 0);
    @(posedge clk);
    #1;
    checkOutput("t6.noClearPulse", dictClear, 0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1, 1, 1, 2'b11, {$urandom, $urandom});
    checkOutput("t6.recoverReady", inReady, 1);
    applyStimulus(0, 0, 1, 2'b11, 64'h0);
    applyStimulus(0, 0, 1, 2'b11, 64'h0);
    checkOutput("t6.recoverLast", outLast, 1);
    applyStimulus(0, 0, 1, 2'b11, 64'h0);
    checkOutput("sb.drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
